// File: rtl/spi_reg_decoder_pkg.sv
// Shared constants and types for the SPI register decoder.
package spi_reg_pkg;

  localparam int unsigned CMD_WR_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // True when the address field of a command byte has no bits above the bank range.
  function automatic logic cmd_addr_ok(input logic [7:0] cmd, input int unsigned addr_w);
    logic [CMD_ADDR_MSB:0] hi;
    hi = cmd[CMD_ADDR_MSB:0] >> addr_w;
    return (hi == '0);
  endfunction

endpackage

// File: rtl/spi_reg_decoder_if.sv
// Byte-stream and register-bank signal bundle between SPI receiver, decoder and consumers.
interface spi_reg_decoder_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]                rx_data_in;
  logic                      rx_valid_in;
  logic                      transaction_valid_in;
  logic                      reg_wr_en_out;
  logic [ADDR_W-1:0]         reg_addr_out;
  logic [7:0]                reg_data_out;
  logic                      addr_err_out;
  logic [8*(2**ADDR_W)-1:0]  regs_out;

  // Receiver side: supplies bytes, observes the bank.
  modport master (
    output rx_data_in, rx_valid_in, transaction_valid_in,
    input  reg_wr_en_out, reg_addr_out, reg_data_out, addr_err_out, regs_out
  );

  // Decoder side.
  modport slave (
    input  rx_data_in, rx_valid_in, transaction_valid_in,
    output reg_wr_en_out, reg_addr_out, reg_data_out, addr_err_out, regs_out
  );
endinterface

// File: rtl/spi_reg_decoder_bank.sv
// spi_reg_bank: 2**ADDR_W x 8 register array, one synchronous write port, flat read vector.
module spi_reg_bank #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     wr_en_in,
  input  logic [ADDR_W-1:0]        wr_addr_in,
  input  logic [7:0]               wr_data_in,
  output logic [8*(2**ADDR_W)-1:0] regs_out
);
  localparam int unsigned NREG = 2**ADDR_W;

  logic [NREG-1:0][7:0] mem_q, mem_d;

  // Write port: replace the addressed byte when enabled.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_in) mem_d[wr_addr_in] = wr_data_in;
  end

  // Bank storage, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  assign regs_out = mem_q;
endmodule

// File: rtl/spi_reg_decoder.sv
// spi_reg_decoder: parses command byte + data bytes from the SPI receiver into a register bank.
// Optional feature: SPI_REG_AUTOINC_EN enables burst writes with wrapping address increment;
// without it only the first data byte of a transaction is written.
module spi_reg_decoder
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input logic              clk_in,
  input logic              reset_in,
  spi_reg_decoder_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              byte_ev, cmd_ev, data_ev, cmd_ok, cmd_accept;

  // A byte only counts while chip-select is active; a strobe coincident with its fall is dropped.
  assign byte_ev    = bus.rx_valid_in & bus.transaction_valid_in;
  assign cmd_ok     = cmd_addr_ok(bus.rx_data_in, ADDR_W);
  assign cmd_accept = bus.rx_data_in[CMD_WR_BIT] & cmd_ok;
  // IDLE with chip-select high doubles as CMD so a byte arriving with the select edge is the command.
  assign cmd_ev     = byte_ev & ((state_q == ST_CMD) | ((state_q == ST_IDLE) & ~hold_q));
  assign data_ev    = byte_ev & (state_q == ST_DATA);

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; loss of chip-select overrides everything.
  always_comb begin
    state_d = state_q;
    if (!bus.transaction_valid_in) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!hold_q) begin
            if (byte_ev) state_d = cmd_accept ? ST_DATA : ST_DISCARD;
            else         state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_ev) state_d = cmd_accept ? ST_DATA : ST_DISCARD;
        end
        ST_DATA: begin
`ifdef SPI_REG_AUTOINC_EN
          state_d = ST_DATA;
`else
          if (byte_ev) state_d = ST_DISCARD;
`endif
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Pointer, write-report and error-pulse logic.
  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = data_ev;
    err_d   = cmd_ev & ~cmd_ok;
    // After reset, IDLE stays blocked until chip-select has been seen low.
    hold_d  = hold_q & bus.transaction_valid_in;
    if (cmd_ev) begin
      ptr_d = bus.rx_data_in[ADDR_W-1:0];
    end else if (data_ev) begin
      ptr_d  = ptr_q + ADDR_W'(1);
      addr_d = ptr_q;
      data_d = bus.rx_data_in;
    end
  end

  spi_reg_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .wr_en_in   (data_ev),
    .wr_addr_in (ptr_q),
    .wr_data_in (bus.rx_data_in),
    .regs_out   (bus.regs_out)
  );

  assign bus.reg_wr_en_out = wr_en_q;
  assign bus.reg_addr_out  = addr_q;
  assign bus.reg_data_out  = data_q;
  assign bus.addr_err_out  = err_q;
endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench for spi_reg_decoder (ADDR_W=4); honours SPI_REG_AUTOINC_EN.
module tb_spi_reg_decoder;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned RW   = 8 * NREG;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_reg_decoder_if #(.ADDR_W(AW)) bus ();
  spi_reg_decoder #(.ADDR_W(AW)) dut (.clk_in(clk), .reset_in(rst), .bus(bus));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned wr_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model state
  logic [7:0]        mbank [NREG];
  logic [AW-1:0]     m_addr;
  logic [7:0]        m_data;
  int unsigned       m_wr, m_err;

  typedef struct {
    logic [31:0]  bytes;
    int unsigned  n;
    int unsigned  exp_wr;
    int unsigned  exp_err;
    logic [AW-1:0] exp_addr;
    logic [7:0]   exp_data;
    int unsigned  idx;
    logic [7:0]   exp_val;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(logic [31:0] b, int unsigned n, int unsigned w, int unsigned e,
                              logic [AW-1:0] a, logic [7:0] d, int unsigned idx, logic [7:0] v);
    vec_t t;
    t.bytes = b; t.n = n; t.exp_wr = w; t.exp_err = e;
    t.exp_addr = a; t.exp_data = d; t.idx = idx; t.exp_val = v;
    return t;
  endfunction

  always @(negedge clk) begin
    if (bus.reg_wr_en_out) wr_cnt++;
    if (bus.addr_err_out)  err_cnt++;
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] reg_at(int unsigned idx);
    logic [RW-1:0] r;
    r = bus.regs_out;
    return r[idx*8 +: 8];
  endfunction

  function automatic logic [RW-1:0] model_flat();
    logic [RW-1:0] f;
    for (int unsigned i = 0; i < NREG; i++) f[i*8 +: 8] = mbank[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < NREG; i++) mbank[i] = 8'h00;
    m_addr = '0; m_data = 8'h00;
  endtask

  // Transaction-level rules: command, address range check, burst or single write.
  task automatic model_txn(input logic [7:0] q[$]);
    int unsigned start, a;
    m_wr = 0; m_err = 0;
    if (q.size() == 0) return;
    if (int'(q[0] & 8'h7F) >= NREG) begin
      m_err = 1;
      return;
    end
    if (q[0] < 8'h80) return;
    start = int'(q[0] & 8'h7F);
    for (int unsigned i = 1; i < q.size(); i++) begin
      if (!AUTOINC && i > 1) break;
      a = (start + i - 1) % NREG;
      mbank[a] = q[i];
      m_addr = AW'(a);
      m_data = q[i];
      m_wr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rx_valid_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic send_txn(input logic [7:0] q[$], input int unsigned lead, input int unsigned maxgap);
    @(negedge clk);
    wr_cnt = 0; err_cnt = 0;
    bus.transaction_valid_in = 1'b1;
    repeat (lead) @(negedge clk);
    foreach (q[i]) begin
      bus.rx_valid_in = 1'b1;
      bus.rx_data_in  = q[i];
      @(negedge clk);
      bus.rx_valid_in = 1'b0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
    bus.transaction_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    model_txn(q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    bus.rx_data_in = 8'h00;
    bus.rx_valid_in = 1'b0;
    bus.transaction_valid_in = 1'b0;

    // Reset state
    do_reset();
    chk("reset_regs", bus.regs_out, '0);
    chk("reset_wr_en", RW'(bus.reg_wr_en_out), '0);
    chk("reset_err", RW'(bus.addr_err_out), '0);
    chk("reset_addr", RW'(bus.reg_addr_out), '0);
    chk("reset_data", RW'(bus.reg_data_out), '0);

    // Write latency: command in the select-edge cycle, data next cycle
    @(negedge clk);
    bus.transaction_valid_in = 1'b1;
    bus.rx_valid_in = 1'b1; bus.rx_data_in = 8'h83;
    @(negedge clk);
    bus.rx_data_in = 8'h5A;
    chk("lat_pre_wr_en", RW'(bus.reg_wr_en_out), '0);
    chk("lat_pre_reg3", RW'(reg_at(3)), RW'(8'h00));
    @(negedge clk);
    bus.rx_valid_in = 1'b0;
    chk("lat_wr_en", RW'(bus.reg_wr_en_out), RW'(1));
    chk("lat_reg3", RW'(reg_at(3)), RW'(8'h5A));
    chk("lat_addr", RW'(bus.reg_addr_out), RW'(3));
    chk("lat_data", RW'(bus.reg_data_out), RW'(8'h5A));
    @(negedge clk);
    chk("lat_wr_en_drop", RW'(bus.reg_wr_en_out), '0);
    bus.transaction_valid_in = 1'b0;

    // Table-driven transactions, back-to-back bytes
    do_reset();
    tbl[0] = mk(32'h835A0000, 2, 1, 0, 4'h3, 8'h5A, 3, 8'h5A);
    tbl[1] = mk(32'h8E112233, 4, AUTOINC ? 3 : 1, 0, AUTOINC ? 4'h0 : 4'hE,
                AUTOINC ? 8'h33 : 8'h11, 0, AUTOINC ? 8'h33 : 8'h00);
    tbl[2] = mk(32'hA0770000, 2, 0, 1, AUTOINC ? 4'h0 : 4'hE, AUTOINC ? 8'h33 : 8'h11, 3, 8'h5A);
    tbl[3] = mk(32'h05770000, 2, 0, 0, AUTOINC ? 4'h0 : 4'hE, AUTOINC ? 8'h33 : 8'h11, 5, 8'h00);
    tbl[4] = mk(32'hFF120000, 2, 0, 1, AUTOINC ? 4'h0 : 4'hE, AUTOINC ? 8'h33 : 8'h11,
                15, AUTOINC ? 8'h22 : 8'h00);
    tbl[5] = mk(32'h8F010200, 3, AUTOINC ? 2 : 1, 0, AUTOINC ? 4'h0 : 4'hF,
                AUTOINC ? 8'h02 : 8'h01, 15, 8'h01);
    tbl[6] = mk(32'h80000000, 1, 0, 0, AUTOINC ? 4'h0 : 4'hF, AUTOINC ? 8'h02 : 8'h01,
                0, AUTOINC ? 8'h02 : 8'h00);
    tbl[7] = mk(32'h8CAABB00, 3, AUTOINC ? 2 : 1, 0, AUTOINC ? 4'hD : 4'hC,
                AUTOINC ? 8'hBB : 8'hAA, 13, AUTOINC ? 8'hBB : 8'h00);
    for (int k = 0; k < 8; k++) begin
      q = {};
      for (int unsigned i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].bytes[31 - 8*i -: 8]);
      send_txn(q, 0, 0);
      chk($sformatf("tbl%0d_wr_cnt", k), RW'(wr_cnt), RW'(tbl[k].exp_wr));
      chk($sformatf("tbl%0d_err_cnt", k), RW'(err_cnt), RW'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_addr", k), RW'(bus.reg_addr_out), RW'(tbl[k].exp_addr));
      chk($sformatf("tbl%0d_data", k), RW'(bus.reg_data_out), RW'(tbl[k].exp_data));
      chk($sformatf("tbl%0d_reg%0d", k, tbl[k].idx), RW'(reg_at(tbl[k].idx)), RW'(tbl[k].exp_val));
    end

    // Chip-select falls in the same cycle as a data strobe
    do_reset();
    @(negedge clk);
    wr_cnt = 0;
    bus.transaction_valid_in = 1'b1;
    bus.rx_valid_in = 1'b1; bus.rx_data_in = 8'h84;
    @(negedge clk);
    bus.transaction_valid_in = 1'b0;
    bus.rx_data_in = 8'h99;
    @(negedge clk);
    bus.rx_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_wr_cnt", RW'(wr_cnt), '0);
    chk("drop_reg4", RW'(reg_at(4)), '0);
    send_txn('{8'h81, 8'h42}, 1, 0);
    chk("after_drop_wr_cnt", RW'(wr_cnt), RW'(1));
    chk("after_drop_reg1", RW'(reg_at(1)), RW'(8'h42));

    // Reset in the middle of a transaction with chip-select held
    @(negedge clk);
    bus.transaction_valid_in = 1'b1;
    bus.rx_valid_in = 1'b1; bus.rx_data_in = 8'h82;
    @(negedge clk);
    bus.rx_data_in = 8'h10;
    @(negedge clk);
    bus.rx_valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0; err_cnt = 0;
    bus.rx_valid_in = 1'b1; bus.rx_data_in = 8'h20;
    @(negedge clk);
    bus.rx_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_regs", bus.regs_out, '0);
    chk("rstmid_wr_cnt", RW'(wr_cnt), '0);
    chk("rstmid_err_cnt", RW'(err_cnt), '0);
    chk("rstmid_data", RW'(bus.reg_data_out), '0);
    bus.transaction_valid_in = 1'b0;
    send_txn('{8'h82, 8'h55}, 0, 0);
    chk("rstmid_recover_reg2", RW'(reg_at(2)), RW'(8'h55));

    // Randomized transactions against the reference model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      int unsigned r, nd;
      logic [7:0] cmd;
      r = $urandom_range(0, 7);
      if (r < 5)       cmd = 8'h80 | 8'($urandom_range(0, NREG - 1));
      else if (r == 5) cmd = 8'($urandom);
      else             cmd = 8'($urandom_range(0, NREG - 1));
      q = {cmd};
      nd = $urandom_range(0, 5);
      for (int unsigned i = 0; i < nd; i++) q.push_back(8'($urandom));
      send_txn(q, $urandom_range(0, 2), 2);
      chk($sformatf("rnd%0d_regs", t), bus.regs_out, model_flat());
      chk($sformatf("rnd%0d_wr_cnt", t), RW'(wr_cnt), RW'(m_wr));
      chk($sformatf("rnd%0d_err_cnt", t), RW'(err_cnt), RW'(m_err));
      chk($sformatf("rnd%0d_addr", t), RW'(bus.reg_addr_out), RW'(m_addr));
      chk($sformatf("rnd%0d_data", t), RW'(bus.reg_data_out), RW'(m_data));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
